replication_arbiter: RTL

Shares a single `replication_operator` datapath between two requesters. Each requester offers an operand set (`a`, `b`, `c`) over a valid/ready handshake. The block grants one requester at a time in round-robin order, sequences the shared datapath, and returns the registered 6-bit result `{a, {4{b[0]}}, c[1]}` with the requester ID on a valid/ready output port. It sits between operand producers and any downstream consumer of replicated words, and keeps per-requester service counters for debug.

---
 rtl/replication_pkg.sv | 18 +
 rtl/replication_operator.sv | 22 ++
 rtl/replication_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/replication_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// replication_pkg: shared types and widths for the replication arbiter slice.
// Rev 1.0
// ----------------------------------------------------------------------------
package replication_pkg;

  localparam int REP_Y_W  = 6;
  localparam int REP_ID_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } rep_state_t;

endpackage
`default_nettype wire

// File: rtl/replication_operator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// replication_operator: builds {a, {4{b[0]}}, c[1]} from one operand set.
// Rev 1.0
// ----------------------------------------------------------------------------
module replication_operator
  import replication_pkg::*;
(
  input  logic               a,
  input  logic [1:0]         b,
  input  logic [1:0]         c,
  output logic [REP_Y_W-1:0] y
);

  // b[1] and c[0] do not contribute to the replicated word.
  logic unused_bits;
  assign unused_bits = b[1] ^ c[0];

  assign y = {a, {4{b[0]}}, c[1]};

endmodule
`default_nettype wire

// File: rtl/replication_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// replication_arbiter: round-robin share of one replication_operator between
// two valid/ready requesters, with per-requester delivery counters. Rev 1.0
// ----------------------------------------------------------------------------
module replication_arbiter
  import replication_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_a,
  input  logic [1:0]         req0_b,
  input  logic [1:0]         req0_c,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_a,
  input  logic [1:0]         req1_b,
  input  logic [1:0]         req1_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REP_Y_W-1:0] out_y,
  output logic               out_id,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
);

  rep_state_t            state_q, state_d;
  logic [REP_ID_W-1:0]   last_grant_q;
  logic [REP_ID_W-1:0]   id_q;
  logic [REP_ID_W-1:0]   out_id_q;
  logic                  a_q;
  logic [1:0]            b_q, c_q;
  logic [REP_Y_W-1:0]    y_q, op_y;
  logic                  out_valid_q;
  logic [CNT_W-1:0]      cnt0_q, cnt1_q;
  logic                  grant0, grant1, accept, out_fire;

  // On contention the requester that did not win last time is granted.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || (last_grant_q != '0));
    grant1 = req1_valid && (!req0_valid || (last_grant_q == '0));
  end

  assign req0_ready = (state_q == ST_IDLE) && grant0;
  assign req1_ready = (state_q == ST_IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;
  assign out_fire   = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_CALC;
      ST_CALC:               state_d = ST_OUT;
      ST_OUT:  if (out_fire) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  replication_operator u_op (
    .a (a_q),
    .b (b_q),
    .c (c_q),
    .y (op_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REP_ID_W'(1);
      id_q         <= '0;
      out_id_q     <= '0;
      a_q          <= 1'b0;
      b_q          <= '0;
      c_q          <= '0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      if (accept) begin
        a_q          <= req1_ready ? req1_a : req0_a;
        b_q          <= req1_ready ? req1_b : req0_b;
        c_q          <= req1_ready ? req1_c : req0_c;
        id_q         <= REP_ID_W'(req1_ready);
        last_grant_q <= REP_ID_W'(req1_ready);
      end
      if (state_q == ST_CALC) begin
        y_q         <= op_y;
        out_id_q    <= id_q;
        out_valid_q <= 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        if (out_id_q == '0) cnt0_q <= cnt0_q + CNT_W'(1);
        else                cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = y_q;
  assign out_id    = out_id_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule
`default_nettype wire
